// File: rtl/ci_pkg.sv
// ci_pkg: shared types and constants for the CI bus initiator.
// Provides bus widths, FSM state encoding and the watchdog-off value.
package ci_pkg;

    localparam int ciIdWidth   = 8;
    localparam int ciDataWidth = 32;

    // A load value of zero means "wait for ciDone forever".
    localparam logic [31:0] watchdogDisabled = 32'd0;

    localparam logic [1:0] stateIdle    = 2'd0;
    localparam logic [1:0] stateIssue   = 2'd1;
    localparam logic [1:0] stateWait    = 2'd2;
    localparam logic [1:0] stateRespond = 2'd3;

    typedef enum logic [1:0] {
        stIdle    = stateIdle,
        stIssue   = stateIssue,
        stWait    = stateWait,
        stRespond = stateRespond
    } ciState_e;

endpackage

// File: rtl/ci_watchdog.sv
// ci_watchdog: 32-bit down-counter bounding the wait for ciDone.
// Ports: clock, reset (async, high), load, enable (ciCke),
//        loadValue (reload / disable when 0), expired (count hit 0).
module ci_watchdog
    import ci_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   enable,
    input  logic [ciDataWidth-1:0] loadValue,
    output logic                   expired
);

    logic [ciDataWidth-1:0] count;

    // Counts down only in qualified cycles and rests at zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= loadValue;
        end else if (enable && (count != '0)) begin
            count <= count - 32'd1;
        end
    end

    // A zero load value disables the watchdog entirely.
    assign expired = (count == '0) && (loadValue != watchdogDisabled);

endmodule

// File: rtl/ci_issue_unit.sv
// ci_issue_unit: initiator side of the custom-instruction bus.
// Ports: clock, reset (async, high), hold (freeze, ciCke = ~hold),
//   req{Valid,Ready,N,ValueA,ValueB} request in,
//   rsp{Valid,Ready,Result,Timeout} response out,
//   ci{Start,Cke,N,ValueA,ValueB} to responders, ciDone/ciResult back,
//   strayDone sticky flag for done seen while no CI is outstanding.
module ci_issue_unit
    import ci_pkg::*;
#(
    parameter logic [31:0] timeoutCycles = 32'd0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   hold,
    input  logic                   reqValid,
    output logic                   reqReady,
    input  logic [ciIdWidth-1:0]   reqN,
    input  logic [ciDataWidth-1:0] reqValueA,
    input  logic [ciDataWidth-1:0] reqValueB,
    output logic                   rspValid,
    input  logic                   rspReady,
    output logic [ciDataWidth-1:0] rspResult,
    output logic                   rspTimeout,
    output logic                   ciStart,
    output logic                   ciCke,
    output logic [ciIdWidth-1:0]   ciN,
    output logic [ciDataWidth-1:0] ciValueA,
    output logic [ciDataWidth-1:0] ciValueB,
    input  logic                   ciDone,
    input  logic [ciDataWidth-1:0] ciResult,
    output logic                   strayDone
);

    ciState_e               state;
    ciState_e               stateNext;
    logic                   ciStartNext;
    logic [ciIdWidth-1:0]   ciNNext;
    logic [ciDataWidth-1:0] ciValueANext;
    logic [ciDataWidth-1:0] ciValueBNext;
    logic                   rspValidNext;
    logic [ciDataWidth-1:0] rspResultNext;
    logic                   rspTimeoutNext;
    logic                   strayDoneNext;
    logic                   wdLoad;
    logic                   wdExpired;

    assign ciCke    = ~hold;
    assign reqReady = (state == stIdle);

    ci_watchdog uWatchdog (
        .clock     (clock),
        .reset     (reset),
        .load      (wdLoad),
        .enable    (ciCke),
        .loadValue (timeoutCycles),
        .expired   (wdExpired)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= stIdle;
            ciStart    <= 1'b0;
            ciN        <= '0;
            ciValueA   <= '0;
            ciValueB   <= '0;
            rspValid   <= 1'b0;
            rspResult  <= '0;
            rspTimeout <= 1'b0;
            strayDone  <= 1'b0;
        end else begin
            state      <= stateNext;
            ciStart    <= ciStartNext;
            ciN        <= ciNNext;
            ciValueA   <= ciValueANext;
            ciValueB   <= ciValueBNext;
            rspValid   <= rspValidNext;
            rspResult  <= rspResultNext;
            rspTimeout <= rspTimeoutNext;
            strayDone  <= strayDoneNext;
        end
    end

    always_comb begin
        stateNext      = state;
        ciStartNext    = ciStart;
        ciNNext        = ciN;
        ciValueANext   = ciValueA;
        ciValueBNext   = ciValueB;
        rspValidNext   = rspValid;
        rspResultNext  = rspResult;
        rspTimeoutNext = rspTimeout;
        wdLoad         = 1'b0;

        unique case (state)
            stIdle: begin
                if (reqValid && !hold) begin
                    ciNNext      = reqN;
                    ciValueANext = reqValueA;
                    ciValueBNext = reqValueB;
                    ciStartNext  = 1'b1;
                    stateNext    = stIssue;
                end
            end
            stIssue: begin
                // The strobe only counts once ciCke is high.
                if (!hold) begin
                    ciStartNext = 1'b0;
                    if (ciDone) begin
                        rspValidNext   = 1'b1;
                        rspResultNext  = ciResult;
                        rspTimeoutNext = 1'b0;
                        stateNext      = stRespond;
                    end else begin
                        wdLoad    = 1'b1;
                        stateNext = stWait;
                    end
                end
            end
            stWait: begin
                // A real done beats a simultaneous expiry.
                if (ciDone) begin
                    rspValidNext   = 1'b1;
                    rspResultNext  = ciResult;
                    rspTimeoutNext = 1'b0;
                    stateNext      = stRespond;
                end else if (wdExpired) begin
                    rspValidNext   = 1'b1;
                    rspResultNext  = '0;
                    rspTimeoutNext = 1'b1;
                    stateNext      = stRespond;
                end
            end
            stRespond: begin
                if (rspReady) begin
                    rspValidNext = 1'b0;
                    stateNext    = stIdle;
                end
            end
            default: begin
                stateNext = stIdle;
            end
        endcase

        strayDoneNext = strayDone |
            (ciDone & ((state == stIdle) | (state == stRespond)));
    end

endmodule

// File: tb/tb_ci_issue_unit.sv
// tb_ci_issue_unit: directed and randomized checks of ci_issue_unit
// against a transaction-level reference model of the CI initiator.
module tb_ci_issue_unit;

    localparam logic [31:0] K = 32'd10;

    logic        clock      = 1'b0;
    logic        reset      = 1'b1;
    logic        hold       = 1'b0;
    logic        reqValid   = 1'b0;
    logic        reqReady;
    logic [7:0]  reqN       = 8'd0;
    logic [31:0] reqValueA  = 32'd0;
    logic [31:0] reqValueB  = 32'd0;
    logic        rspValid;
    logic        rspReady   = 1'b1;
    logic [31:0] rspResult;
    logic        rspTimeout;
    logic        ciStart;
    logic        ciCke;
    logic [7:0]  ciN;
    logic [31:0] ciValueA;
    logic [31:0] ciValueB;
    logic        ciDone     = 1'b0;
    logic [31:0] ciResult   = 32'd0;
    logic        strayDone;

    int total = 0;
    int bad = 0;
    int startCount = 0;

    // Bench responder knobs: delay 0 = combinational, -1 = never.
    int          respDelay = -1;
    int          cdown = 0;
    bit          rndDelay = 1'b0;
    int          noisePct = 0;
    logic [31:0] respVal = 32'd0;
    int          delays [9] = '{0, 1, 2, 3, 5, 10, 11, 12, -1};

    always #5 clock = ~clock;

    ci_issue_unit #(.timeoutCycles(K)) dut (
        .clock      (clock),
        .reset      (reset),
        .hold       (hold),
        .reqValid   (reqValid),
        .reqReady   (reqReady),
        .reqN       (reqN),
        .reqValueA  (reqValueA),
        .reqValueB  (reqValueB),
        .rspValid   (rspValid),
        .rspReady   (rspReady),
        .rspResult  (rspResult),
        .rspTimeout (rspTimeout),
        .ciStart    (ciStart),
        .ciCke      (ciCke),
        .ciN        (ciN),
        .ciValueA   (ciValueA),
        .ciValueB   (ciValueB),
        .ciDone     (ciDone),
        .ciResult   (ciResult),
        .strayDone  (strayDone)
    );

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b want %0b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction and its lifecycle.
    bit          mBusy = 0;
    bit          mStart = 0;
    bit          mWait = 0;
    bit          mRsp = 0;
    bit          mStray = 0;
    bit          mTo = 0;
    logic [7:0]  mN = 0;
    logic [31:0] mA = 0;
    logic [31:0] mB = 0;
    logic [31:0] mRes = 0;
    int          mCke = 0;

    task automatic deliver(input logic [31:0] r, input bit t);
        mWait = 0;
        mRsp  = 1;
        mRes  = r;
        mTo   = t;
    endtask

    task automatic modelCompare();
        chk1("reqReady", reqReady, !mBusy);
        chk1("ciStart", ciStart, mStart);
        chk1("ciCke", ciCke, !hold);
        chk1("rspValid", rspValid, mRsp);
        chk1("strayDone", strayDone, mStray);
        if (mBusy || reset) begin
            chk32("ciN", {24'd0, ciN}, {24'd0, mN});
            chk32("ciValueA", ciValueA, mA);
            chk32("ciValueB", ciValueB, mB);
        end
        if (mRsp || reset) begin
            chk32("rspResult", rspResult, mRes);
            chk1("rspTimeout", rspTimeout, mTo);
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            mBusy = 0; mStart = 0; mWait = 0; mRsp = 0; mStray = 0;
            mTo = 0; mN = 0; mA = 0; mB = 0; mRes = 0; mCke = 0;
            modelCompare();
        end else begin
            modelCompare();
            if (ciStart && ciCke) startCount++;
            if (ciDone && (!mBusy || mRsp)) mStray = 1;
            if (mRsp) begin
                if (rspReady) begin
                    mRsp  = 0;
                    mBusy = 0;
                end
            end else if (!mBusy) begin
                if (reqValid && !hold) begin
                    mBusy  = 1;
                    mStart = 1;
                    mN = reqN; mA = reqValueA; mB = reqValueB;
                end
            end else if (mStart) begin
                if (!hold) begin
                    mStart = 0;
                    if (ciDone) deliver(ciResult, 0);
                    else begin
                        mWait = 1;
                        mCke  = 0;
                    end
                end
            end else if (mWait) begin
                // mCke = qualified cycles already spent waiting.
                if (ciDone) deliver(ciResult, 0);
                else if (K != 0 && mCke >= int'(K)) deliver(32'd0, 1);
                else if (!hold) mCke++;
            end
        end
    end

    task automatic resp();
        bit fire;
        int d;
        fire = 0;
        if (cdown > 0) begin
            cdown--;
            if (cdown == 0) fire = 1;
        end
        if (ciStart && !hold) begin
            d = rndDelay ? delays[$urandom_range(8)] : respDelay;
            if (d == 0) fire = 1;
            else if (d > 0) cdown = d;
        end
        if (noisePct > 0 && int'($urandom_range(99)) < noisePct) fire = 1;
        ciDone   = fire;
        ciResult = fire ? (rndDelay ? $urandom : respVal) : 32'd0;
    endtask

    task automatic cyc1(input bit h, input bit rv, input bit rr);
        @(posedge clock);
        #1;
        hold     = h;
        reqValid = rv;
        rspReady = rr;
        resp();
        #1;
    endtask

    task automatic rstep();
        reqN      = 8'($urandom);
        reqValueA = $urandom;
        reqValueB = $urandom;
        cyc1($urandom_range(99) < 25, $urandom_range(99) < 60,
             $urandom_range(99) < 60);
    endtask

    int sc0;

    initial begin
        hold = 1'b1;
        #1;
        chk1("reset ciCke held", ciCke, 1'b0);
        hold = 1'b0;
        #1;
        chk1("reset ciCke free", ciCke, 1'b1);
        chk1("reset reqReady", reqReady, 1'b1);
        chk1("reset ciStart", ciStart, 1'b0);
        chk1("reset rspValid", rspValid, 1'b0);
        chk1("reset strayDone", strayDone, 1'b0);
        repeat (2) cyc1(0, 0, 1);
        reset = 1'b0;

        // Basic issue with a two-cycle responder.
        reqN = 8'h05; reqValueA = 32'd3; reqValueB = 32'd0;
        respDelay = 2; respVal = 32'hCAFE;
        cyc1(0, 1, 1);
        cyc1(0, 0, 1);
        chk1("basic start", ciStart, 1'b1);
        chk32("basic n", {24'd0, ciN}, 32'h05);
        chk32("basic a", ciValueA, 32'd3);
        cyc1(0, 0, 1);
        chk1("basic start once", ciStart, 1'b0);
        chk32("basic a stable", ciValueA, 32'd3);
        cyc1(0, 0, 1);
        chk1("basic no rsp yet", rspValid, 1'b0);
        cyc1(0, 0, 1);
        chk1("basic rsp", rspValid, 1'b1);
        chk32("basic result", rspResult, 32'hCAFE);
        chk1("basic timeout", rspTimeout, 1'b0);
        cyc1(0, 0, 1);
        chk1("basic idle", reqReady, 1'b1);

        // Hold during start.
        reqN = 8'h22; reqValueA = 32'h77; respDelay = 1; respVal = 32'h1234;
        cyc1(0, 1, 1);
        sc0 = startCount;
        for (int i = 0; i < 3; i++) begin
            cyc1(1, 0, 1);
            chk1("hold start high", ciStart, 1'b1);
            chk1("hold cke low", ciCke, 1'b0);
        end
        cyc1(0, 0, 1);
        chk1("hold start qual", ciStart, 1'b1);
        cyc1(0, 0, 1);
        chk1("hold start drop", ciStart, 1'b0);
        cyc1(0, 0, 1);
        chk1("hold rsp", rspValid, 1'b1);
        chk32("hold result", rspResult, 32'h1234);
        chk32("hold one start", 32'(startCount - sc0), 32'd1);
        cyc1(0, 0, 1);

        // Watchdog timeout: response at start + 12.
        respDelay = -1;
        cyc1(0, 1, 1);
        cyc1(0, 0, 1);
        for (int i = 0; i < 11; i++) cyc1(0, 0, 1);
        chk1("wd not early", rspValid, 1'b0);
        cyc1(0, 0, 1);
        chk1("wd rsp", rspValid, 1'b1);
        chk1("wd timeout", rspTimeout, 1'b1);
        chk32("wd result", rspResult, 32'd0);
        cyc1(0, 0, 1);

        // Done in the expiry cycle.
        respDelay = 11; respVal = 32'hBEEF;
        cyc1(0, 1, 1);
        cyc1(0, 0, 1);
        for (int i = 0; i < 12; i++) cyc1(0, 0, 1);
        chk1("tie rsp", rspValid, 1'b1);
        chk1("tie timeout", rspTimeout, 1'b0);
        chk32("tie result", rspResult, 32'hBEEF);
        cyc1(0, 0, 1);

        // Backpressure with a second request waiting.
        reqN = 8'h33; respDelay = 1; respVal = 32'h5A5A;
        cyc1(0, 1, 1);
        cyc1(0, 0, 1);
        cyc1(0, 0, 1);
        reqN = 8'h44;
        for (int i = 0; i < 5; i++) begin
            cyc1(0, 1, 0);
            chk1("bp rsp held", rspValid, 1'b1);
            chk1("bp not ready", reqReady, 1'b0);
            chk32("bp result held", rspResult, 32'h5A5A);
            chk1("bp no start", ciStart, 1'b0);
        end
        cyc1(0, 1, 1);
        chk1("bp handshake", rspValid, 1'b1);
        cyc1(0, 1, 1);
        chk1("bp idle", reqReady, 1'b1);
        chk1("bp idle no start", ciStart, 1'b0);
        cyc1(0, 0, 1);
        chk1("bp second start", ciStart, 1'b1);
        chk32("bp second n", {24'd0, ciN}, 32'h44);
        repeat (3) cyc1(0, 0, 1);

        // Stray done while idle.
        chk1("stray clear", strayDone, 1'b0);
        cyc1(0, 0, 1);
        ciDone = 1'b1;
        ciResult = 32'hDEAD;
        cyc1(0, 0, 1);
        chk1("stray set", strayDone, 1'b1);

        // Reset in the middle of WAIT; the late done is stray.
        reqN = 8'h55; reqValueA = 32'h99; respDelay = 8;
        cyc1(0, 1, 1);
        cyc1(0, 0, 1);
        cyc1(0, 0, 1);
        cyc1(0, 0, 1);
        #1 reset = 1'b1;
        #1;
        chk1("rst reqReady", reqReady, 1'b1);
        chk32("rst ciN", {24'd0, ciN}, 32'd0);
        chk32("rst ciValueA", ciValueA, 32'd0);
        chk1("rst strayDone", strayDone, 1'b0);
        cyc1(0, 0, 1);
        cyc1(0, 0, 1);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) cyc1(0, 0, 1);
        chk1("late done pending", strayDone, 1'b0);
        cyc1(0, 0, 1);
        chk1("late done stray", strayDone, 1'b1);

        // Randomized traffic with a mid-run reset.
        rndDelay = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                reset = 1'b1;
                cyc1(0, 0, 1);
                cyc1(0, 0, 1);
                reset = 1'b0;
            end
            noisePct = (i < 1000) ? 0 : 3;
            rstep();
        end
        cyc1(0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
